// File: rtl/out_uart_reporter.sv
// Watches the SoC "out" register and sends every new value over an 8N1 UART
// as upper-case ASCII hex text followed by "\r\n", MSB nibble first.
module out_uart_reporter #(
    parameter int CLK_FREQ = 6000000,
    parameter int BAUD     = 115200,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      value,
    input  logic             report_en,
    input  logic             report_req,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] overrun_cnt
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_next;
    logic [31:0]       shadow, shadow_next;
    logic [31:0]       last_sent, last_sent_next;
    logic [31:0]       value_q;
    logic [3:0]        char_idx, char_idx_next;
    logic [2:0]        bit_idx, bit_idx_next;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_next;
    logic              tx_next, busy_next;
    logic [3:0]        nibble;
    logic [7:0]        cur_char;
    logic              fire, bit_end;

    // Nibble i lives at shadow[4*(7-i)+3 -: 4]; 7-i is the bitwise inverse of a 3-bit i.
    always_comb begin
        nibble = shadow[{~char_idx[2:0], 2'b11} -: 4];
        if (char_idx == 4'd8)
            cur_char = 8'h0D;
        else if (char_idx == 4'd9)
            cur_char = 8'h0A;
        else if (nibble < 4'd10)
            cur_char = 8'h30 + {4'h0, nibble};
        else
            cur_char = 8'h37 + {4'h0, nibble};
    end

    assign fire    = report_req | (report_en & (value != last_sent));
    assign bit_end = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_next     = state;
        shadow_next    = shadow;
        last_sent_next = last_sent;
        char_idx_next  = char_idx;
        bit_idx_next   = bit_idx;
        baud_cnt_next  = baud_cnt;
        tx_next        = tx;
        busy_next      = busy;
        unique case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (fire) begin
                    shadow_next    = value;
                    last_sent_next = value;
                    busy_next      = 1'b1;
                    char_idx_next  = 4'd0;
                    baud_cnt_next  = '0;
                    tx_next        = 1'b0;
                    state_next     = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = 3'd0;
                    tx_next       = cur_char[0];
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = cur_char[bit_idx + 3'd1];
                    end
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (char_idx == 4'd9) begin
                        busy_next  = 1'b0;
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        char_idx_next = char_idx + 4'd1;
                        tx_next       = 1'b0;
                        state_next    = START;
                    end
                end else begin
                    baud_cnt_next = baud_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            shadow    <= '0;
            last_sent <= '0;
            char_idx  <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            shadow    <= shadow_next;
            last_sent <= last_sent_next;
            char_idx  <= char_idx_next;
            bit_idx   <= bit_idx_next;
            baud_cnt  <= baud_cnt_next;
            tx        <= tx_next;
            busy      <= busy_next;
        end
    end

    // Changes seen while a frame is on the line are dropped, so count them.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            value_q     <= '0;
            overrun_cnt <= '0;
        end else begin
            value_q <= value;
            if (busy && (value != value_q) && (overrun_cnt != '1))
                overrun_cnt <= overrun_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_out_uart_reporter.sv
// Randomized bench for out_uart_reporter: frames are predicted as hex text and
// compared bit-for-bit on tx, overrun counts are predicted from driven changes.
module tb_out_uart_reporter;

    localparam int CPB   = 8;
    localparam int FRAME = 100 * CPB;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] value = '0;
    logic        report_en = 1'b0;
    logic        report_req = 1'b0;
    logic        tx;
    logic        busy;
    logic [7:0]  overrun_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    int model_overrun = 0;

    always #5 clk = ~clk;

    out_uart_reporter #(.CLK_FREQ(8), .BAUD(1), .CNT_W(8)) dut (
        .clk(clk), .resetn(resetn), .value(value), .report_en(report_en),
        .report_req(report_req), .tx(tx), .busy(busy), .overrun_cnt(overrun_cnt)
    );

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    function automatic string frame_text(input logic [31:0] v);
        string hexd = "0123456789ABCDEF";
        string s = "";
        for (int i = 7; i >= 0; i--)
            s = {s, $sformatf("%c", hexd[int'(v[4*i +: 4])])};
        return {s, $sformatf("%c%c", 8'h0D, 8'h0A)};
    endfunction

    function automatic logic expected_bit(input string s, input int k);
        int c = k / (10 * CPB);
        int p = (k % (10 * CPB)) / CPB;
        logic [7:0] ch;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        ch = s[c];
        return ch[p-1];
    endfunction

    function automatic int sat(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    task automatic wait_start(input int max_wait, output int waited, output bit found);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx !== 1'b0 && waited < max_wait);
        found = (tx === 1'b0);
    endtask

    // Called on the first start-bit sample; consumes the frame plus the busy-low sample after it.
    task automatic capture_frame(input logic [31:0] v, input string name);
        string exp_s = frame_text(v);
        logic [7:0] got [10];
        int bad = 0, first_bad = -1, busy_bad = 0, bad_char = -1;
        for (int k = 0; k < FRAME; k++) begin
            int c = k / (10 * CPB);
            int p = (k % (10 * CPB)) / CPB;
            if (k > 0) @(negedge clk);
            if (tx !== expected_bit(exp_s, k)) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (busy !== 1'b1) busy_bad++;
            if ((k % CPB) == CPB / 2 && p >= 1 && p <= 8) got[c][p-1] = tx;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL %s_wave: %0d wrong tx samples, first at %0d (value %08h)", name, bad, first_bad, v);
        end
        for (int c = 0; c < 10; c++)
            if (bad_char < 0 && got[c] !== exp_s[c]) bad_char = c;
        tests_run++;
        if (bad_char >= 0) begin
            tests_failed++;
            $display("[TB] FAIL %s_text: char %0d got %02h expected %02h", name, bad_char, got[bad_char], exp_s[bad_char]);
        end
        tests_run++;
        if (busy_bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL %s_busy_high: busy low on %0d of %0d frame cycles, expected 0", name, busy_bad, FRAME);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s_end: busy=%b tx=%b at frame+1, expected busy=0 tx=1", name, busy, tx);
        end
    endtask

    task automatic expect_start(input string name, output bit ok);
        int waited;
        bit found;
        wait_start(10, waited, found);
        tests_run++;
        ok = found && waited == 1;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL %s_latency: start after %0d cycles (found=%0b), expected 1", name, waited, found);
        end
    endtask

    task automatic expect_no_frame(input int cycles, input string name);
        int waited;
        bit found;
        wait_start(cycles, waited, found);
        tests_run++;
        if (found) begin
            tests_failed++;
            $display("[TB] FAIL %s: start bit after %0d cycles, expected none in %0d", name, waited, cycles);
        end
    endtask

    task automatic check_overrun(input string name);
        tests_run++;
        if (overrun_cnt !== 8'(model_overrun)) begin
            tests_failed++;
            $display("[TB] FAIL %s: overrun_cnt=%0d expected %0d", name, overrun_cnt, model_overrun);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        value = '0;
        report_en = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || overrun_cnt !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: tx=%b busy=%b ovr=%0d expected 1 0 0", tx, busy, overrun_cnt);
        end
        resetn = 1'b1;
    endtask

    task automatic test_idle_zero();
        int bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL idle_zero: %0d cycles with activity, expected 0", bad);
        end
    endtask

    task automatic test_first_frame_with_overrun();
        bit ok;
        logic [31:0] seq [3] = '{32'd1, 32'd2, 32'd3};
        value = 32'hDEADBEEF;
        expect_start("deadbeef", ok);
        if (!ok) return;
        fork
            capture_frame(32'hDEADBEEF, "deadbeef");
            begin
                repeat ($urandom_range(50, 150)) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    if (seq[i] != value) model_overrun = sat(model_overrun + 1);
                    value = seq[i];
                    repeat ($urandom_range(1, 20)) @(negedge clk);
                end
            end
        join
        check_overrun("overrun_three");
    endtask

    task automatic test_back_to_back();
        bit ok;
        expect_start("followup", ok);
        if (!ok) return;
        capture_frame(32'd3, "followup");
        expect_no_frame(1200, "followup_single");
        check_overrun("overrun_hold");
    endtask

    task automatic test_manual_request();
        bit ok;
        report_en = 1'b0;
        value = 32'h0000A5F0;
        expect_no_frame(1000, "disabled_no_frame");
        report_req = 1'b1;
        expect_start("request", ok);
        report_req = 1'b0;
        if (!ok) return;
        fork
            capture_frame(32'h0000A5F0, "request");
            begin
                repeat ($urandom_range(100, 600)) @(negedge clk);
                report_req = 1'b1;
                @(negedge clk);
                report_req = 1'b0;
            end
        join
        expect_no_frame(1200, "request_ignored");
        check_overrun("request_no_count");
    endtask

    task automatic test_enable_pending();
        bit ok;
        logic [31:0] v = $urandom;
        if (v == 32'h0000A5F0) v = ~v;
        value = v;
        expect_no_frame(100, "pending_no_frame");
        report_en = 1'b1;
        expect_start("pending", ok);
        if (ok) capture_frame(v, "pending");
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        logic [31:0] v = $urandom;
        if (v == value) v = ~v;
        value = v;
        expect_start("pre_reset", ok);
        if (!ok) return;
        repeat (2 * 10 * CPB + $urandom_range(1, 9 * CPB)) @(negedge clk);
        resetn = 1'b0;
        value = 32'h12345678;
        model_overrun = 0;
        @(negedge clk);
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || overrun_cnt !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_abort: tx=%b busy=%b ovr=%0d expected 1 0 0", tx, busy, overrun_cnt);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        expect_start("post_reset", ok);
        if (ok) capture_frame(32'h12345678, "post_reset");
    endtask

    task automatic test_saturation();
        bit ok;
        logic [31:0] v = $urandom;
        if (v == value) v = ~v;
        value = v;
        expect_start("saturate", ok);
        if (!ok) return;
        fork
            capture_frame(v, "saturate");
            for (int i = 1; i <= 300; i++) begin
                @(negedge clk);
                value = v + 32'(i);
                model_overrun = sat(model_overrun + 1);
            end
        join
        check_overrun("overrun_saturate");
        expect_start("latest_only", ok);
        if (ok) capture_frame(v + 32'd300, "latest_only");
        check_overrun("overrun_stays_saturated");
    endtask

    task automatic test_random_frames();
        bit ok;
        for (int n = 0; n < 3; n++) begin
            logic [31:0] v = $urandom;
            if (v == value) v = v ^ 32'h1;
            value = v;
            expect_start("random", ok);
            if (ok) capture_frame(v, "random");
        end
    endtask

    initial begin
        test_reset();
        test_idle_zero();
        test_first_frame_with_overrun();
        test_back_to_back();
        test_manual_request();
        test_enable_pending();
        test_reset_mid_frame();
        test_saturation();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
